// File: rtl/fp_mul_pipe.sv
// Pipelined sign/exponent/mantissa multiplier with truncate/RNE rounding, saturation and exception flags.
// Stages: decode -> multiply -> normalise/round/pack. An output stall freezes all three stages.
module fp_mul_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 7,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 rnd_mode,
  input  logic                 sat_en,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] product,
  output logic [3:0]           flags,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EW-1:0]    BIAS_E   = EW'(BIAS);
  localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     NAN_WORD = {1'b0, {(EXP_W+MAN_W){1'b1}}};
  localparam logic [MAN_W-1:0] MAN_ONES = {MAN_W{1'b1}};
  localparam logic [MAN_W-1:0] MAN_MAXF = {{(MAN_W-1){1'b1}}, 1'b0};

  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  logic [EXP_W-1:0] ea, eb;
  logic             a_nan, b_nan, a_zero, b_zero;
  assign ea     = a[W-2 -: EXP_W];
  assign eb     = b[W-2 -: EXP_W];
  assign a_nan  = (&ea) & (&a[MAN_W-1:0]);
  assign b_nan  = (&eb) & (&b[MAN_W-1:0]);
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;

  logic             s1_vld, s1_sign, s1_nan, s1_zero, s1_rnd, s1_sat;
  logic [EW-1:0]    s1_exp;
  logic [MAN_W:0]   s1_ma, s1_mb;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_zero <= 1'b0;
      s1_rnd  <= 1'b0;
      s1_sat  <= 1'b0;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
      s1_tag  <= '0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_sign <= a[W-1] ^ b[W-1];
      s1_nan  <= a_nan | b_nan;
      s1_zero <= a_zero | b_zero;
      s1_rnd  <= rnd_mode;
      s1_sat  <= sat_en;
      s1_exp  <= EW'(ea) + EW'(eb) - BIAS_E;
      s1_ma   <= {1'b1, a[MAN_W-1:0]};
      s1_mb   <= {1'b1, b[MAN_W-1:0]};
      s1_tag  <= in_tag;
    end
  end

  logic             s2_vld, s2_sign, s2_nan, s2_zero, s2_rnd, s2_sat;
  logic [EW-1:0]    s2_exp;
  logic [PW-1:0]    s2_prod;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_nan  <= 1'b0;
      s2_zero <= 1'b0;
      s2_rnd  <= 1'b0;
      s2_sat  <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
      s2_tag  <= '0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_zero <= s1_zero;
      s2_rnd  <= s1_rnd;
      s2_sat  <= s1_sat;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_tag  <= s1_tag;
    end
  end

  // Normalise so the hidden bit sits at PW-1, then split fraction / guard / sticky.
  logic             top, guard, sticky, inc, inexact, ovf, unf;
  logic [PW-1:0]    norm;
  logic [MAN_W-1:0] frac, frac_f;
  logic [MAN_W:0]   mant_r;
  logic [EW-1:0]    exp_f;
  logic [W-1:0]     res;
  logic [3:0]       flg;

  always_comb begin
    top     = s2_prod[PW-1];
    norm    = top ? s2_prod : {s2_prod[PW-2:0], 1'b0};
    frac    = norm[PW-2 -: MAN_W];
    guard   = norm[PW-2-MAN_W];
    sticky  = |norm[PW-3-MAN_W:0];
    inc     = s2_rnd & guard & (sticky | frac[0]);
    mant_r  = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    frac_f  = mant_r[MAN_W-1:0];
    exp_f   = s2_exp + EW'(top) + EW'(mant_r[MAN_W]);
    inexact = guard | sticky;
    ovf     = ($signed(exp_f) > $signed(EMAX)) || ((exp_f == EMAX) && (frac_f == MAN_ONES));
    unf     = exp_f[EW-1] | (exp_f == '0);

    res = {s2_sign, exp_f[EXP_W-1:0], frac_f};
    flg = {3'b000, inexact};
    if (s2_nan) begin
      res = NAN_WORD;
      flg = 4'b1000;
    end else if (s2_zero) begin
      res = {s2_sign, {(W-1){1'b0}}};
      flg = 4'b0000;
    end else if (ovf) begin
      res = s2_sat ? {s2_sign, {EXP_W{1'b1}}, MAN_MAXF} : NAN_WORD;
      flg = {2'b01, 1'b0, inexact};
    end else if (unf) begin
      res = {s2_sign, {(W-1){1'b0}}};
      flg = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
      flags     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s2_vld;
      product   <= res;
      flags     <= flg;
      out_tag   <= s2_tag;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed arithmetic vectors, a stalled back-to-back stream and reset with ops in flight.
// Expected results are queued when a pair is accepted and popped when the pipe delivers the result.
module tb_fp_mul_pipe;
  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 7;
  localparam int TAG_W = 4;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int NV    = 21;

  // {a, b, rnd_mode, sat_en, product, flags{nan,ovf,unf,inexact}}
  localparam logic [29:0] VT [NV] = '{
    {8'h4C, 8'h46, 1'b1, 1'b1, 8'h5A, 4'b0001},
    {8'h4C, 8'h46, 1'b0, 1'b1, 8'h5A, 4'b0001},
    {8'h00, 8'h46, 1'b1, 1'b1, 8'h00, 4'b0000},
    {8'h3D, 8'h3D, 1'b0, 1'b1, 8'h42, 4'b0001},
    {8'h3D, 8'h3D, 1'b1, 1'b1, 8'h43, 4'b0001},
    {8'h40, 8'hC6, 1'b1, 1'b1, 8'hCE, 4'b0000},
    {8'h3C, 8'h3C, 1'b1, 1'b1, 8'h41, 4'b0000},
    {8'h38, 8'h3C, 1'b1, 1'b1, 8'h3C, 4'b0000},
    {8'h7E, 8'h40, 1'b1, 1'b1, 8'h7E, 4'b0100},
    {8'h7E, 8'h40, 1'b1, 1'b0, 8'h7F, 4'b0100},
    {8'h08, 8'h08, 1'b1, 1'b1, 8'h00, 4'b0011},
    {8'h7F, 8'h00, 1'b1, 1'b1, 8'h7F, 4'b1000},
    {8'h39, 8'h3E, 1'b1, 1'b1, 8'h40, 4'b0001},
    {8'h39, 8'h3E, 1'b0, 1'b1, 8'h3F, 4'b0001},
    {8'h78, 8'h3F, 1'b1, 1'b1, 8'h7E, 4'b0100},
    {8'h78, 8'h3F, 1'b1, 1'b0, 8'h7F, 4'b0100},
    {8'h7E, 8'h38, 1'b1, 1'b0, 8'h7E, 4'b0000},
    {8'h08, 8'h38, 1'b1, 1'b1, 8'h08, 4'b0000},
    {8'h88, 8'h30, 1'b1, 1'b1, 8'h80, 4'b0011},
    {8'h80, 8'h46, 1'b1, 1'b1, 8'h80, 4'b0000},
    {8'hFF, 8'h38, 1'b1, 1'b1, 8'h7F, 4'b1000}
  };

  typedef struct {
    logic [W-1:0]     p;
    logic [3:0]       f;
    logic [TAG_W-1:0] t;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, rnd_mode, sat_en, out_valid, out_ready;
  logic [W-1:0]     a, b, product;
  logic [3:0]       flags;
  logic [TAG_W-1:0] in_tag, out_tag;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .sat_en(sat_en), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .flags(flags), .out_tag(out_tag)
  );

  task automatic drive(input logic [29:0] v, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    a        = v[29:22];
    b        = v[21:14];
    rnd_mode = v[13];
    sat_en   = v[12];
    in_tag   = tag;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    tests++; if (product !== 8'h00) begin fails++; $display("FAIL reset product got %h want 00", product); end
    tests++; if (flags !== 4'b0000) begin fails++; $display("FAIL reset flags got %b want 0000", flags); end
    tests++; if (out_tag !== 4'h0) begin fails++; $display("FAIL reset out_tag got %h want 0", out_tag); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors;
    logic [29:0] v;
    exp_t        e;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      v = VT[i];
      drive(v, TAG_W'(i));
      @(posedge clk);
      e.p = v[11:4]; e.f = v[3:0]; e.t = TAG_W'(i); e.cyc = 0;
      sb.push_back(e);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(posedge clk);
        #1;
        lat++;
      end
      e = sb.pop_front();
      tests++; if (lat !== 3) begin fails++; $display("FAIL vec%0d latency got %0d want 3", i, lat); end
      tests++; if (product !== e.p) begin fails++; $display("FAIL vec%0d product got %h want %h", i, product, e.p); end
      tests++; if (flags !== e.f) begin fails++; $display("FAIL vec%0d flags got %b want %b", i, flags, e.f); end
      tests++; if (out_tag !== e.t) begin fails++; $display("FAIL vec%0d out_tag got %h want %h", i, out_tag, e.t); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [29:0]      v;
    exp_t             e;
    int               idx, got, stalls;
    bit               acc, extra;
    logic [W-1:0]     hold_p;
    logic [3:0]       hold_f;
    logic [TAG_W-1:0] hold_t;
    idx = 0; got = 0; stalls = 0; extra = 1'b0;
    v = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      if (idx < 8) begin
        v = VT[idx];
        drive(v, TAG_W'(idx + 3));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        stalls++;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall in_ready cyc%0d got %b want 0", cyc, in_ready); end
        if (stalls == 1) begin
          hold_p = product; hold_f = flags; hold_t = out_tag;
        end else begin
          tests++;
          if ({product, flags, out_tag} !== {hold_p, hold_f, hold_t}) begin
            fails++;
            $display("FAIL stall stable cyc%0d got %h/%b/%h want %h/%b/%h", cyc, product, flags, out_tag, hold_p, hold_f, hold_t);
          end
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          extra = 1'b1;
        end else begin
          e = sb.pop_front();
          tests++; if (product !== e.p) begin fails++; $display("FAIL stream%0d product got %h want %h", got, product, e.p); end
          tests++; if (flags !== e.f) begin fails++; $display("FAIL stream%0d flags got %b want %b", got, flags, e.f); end
          tests++; if (out_tag !== e.t) begin fails++; $display("FAIL stream%0d out_tag got %h want %h", got, out_tag, e.t); end
          if (cyc < 5) begin
            tests++; if (cyc - e.cyc !== 3) begin fails++; $display("FAIL stream%0d latency got %0d want 3", got, cyc - e.cyc); end
          end
          got++;
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        e.p = v[11:4]; e.f = v[3:0]; e.t = in_tag; e.cyc = cyc;
        sb.push_back(e);
        idx++;
      end
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) extra = 1'b1;
    end
    tests++; if (got !== 8) begin fails++; $display("FAIL stream count got %0d want 8", got); end
    tests++; if (stalls !== 5) begin fails++; $display("FAIL stream stall cycles got %0d want 5", stalls); end
    tests++; if (extra !== 1'b0 || sb.size() !== 0) begin fails++; $display("FAIL stream leftovers extra %b queued %0d want 0 0", extra, sb.size()); end
  endtask

  task automatic test_reset_midstream;
    logic [29:0] v;
    exp_t        e;
    int          lat;
    bit          stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = VT[6];
      drive(v, TAG_W'(i + 8));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst inflight out_valid got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
    tests++; if ({product, flags, out_tag} !== 16'h0000) begin fails++; $display("FAIL midrst outputs got %h/%b/%h want 0", product, flags, out_tag); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    stale = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) stale = 1'b1;
      @(posedge clk);
      #1;
    end
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL midrst stale result got %b want 0", stale); end
    v = VT[0];
    drive(v, 4'h5);
    @(posedge clk);
    e.p = v[11:4]; e.f = v[3:0]; e.t = 4'h5; e.cyc = 0;
    sb.push_back(e);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    tests++; if (lat !== 3) begin fails++; $display("FAIL midrst latency got %0d want 3", lat); end
    tests++; if ({product, flags, out_tag} !== {e.p, e.f, e.t}) begin
      fails++; $display("FAIL midrst result got %h/%b/%h want %h/%b/%h", product, flags, out_tag, e.p, e.f, e.t);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    rnd_mode  = 1'b0;
    sat_en    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset;
    test_vectors;
    test_back_to_back;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end
endmodule
